joy_sega_multi: RTL and testbench

JOY_SEGA_MULTI -- requirements
Module: joy_sega_multi

---
 rtl/joy_sega_pkg.sv | 42 ++++
 rtl/joy_sega_port.sv | 100 ++++++++++
 rtl/joy_sega_multi.sv | 68 ++++++
 tb/tb_joy_sega_multi.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/joy_sega_pkg.sv
// Shared constants for the multi-port Sega DB9 pad reader: poll phases,
// joy_o bit positions, raw pin positions and the select-line schedule.
package joy_sega_pkg;

  localparam int MAX_PORTS = 4;

  localparam int PH_READ_DIR = 2;
  localparam int PH_READ_MD  = 3;
  localparam int PH_DETECT6  = 6;
  localparam int PH_COMMIT   = 7;

  // joy_o bit positions within one port: {M,X,Y,Z,S,A,C,B,R,L,D,U}
  localparam int JB_U = 0;
  localparam int JB_D = 1;
  localparam int JB_L = 2;
  localparam int JB_R = 3;
  localparam int JB_B = 4;
  localparam int JB_C = 5;
  localparam int JB_A = 6;
  localparam int JB_S = 7;
  localparam int JB_Z = 8;
  localparam int JB_Y = 9;
  localparam int JB_X = 10;
  localparam int JB_M = 11;

  // raw pin positions within one port: {p9,p6,right,left,down,up}
  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_P6    = 4;
  localparam int PIN_P9    = 5;

  // Select level held during phase ph; the third low pulse only exists when
  // six-button probing is enabled.
  function automatic logic sel_level(input int ph, input logic six_en);
    if (ph == 0 || ph == 2) return 1'b0;
    if (ph == 4) return !six_en;
    return 1'b1;
  endfunction

endpackage

// File: rtl/joy_sega_port.sv
// One DB9 port: pin synchroniser, per-cycle shadow decode, Mega Drive /
// six-button detection and the atomically committed output register.
module joy_sega_port
  import joy_sega_pkg::*;
#(
  parameter int PW = 6
) (
  input  logic          clk_i,
  input  logic          res_n_i,
  input  logic          tick_i,
  input  logic          six_en_i,
  input  logic [PW-1:0] ph_nxt_i,
  input  logic [5:0]    pad_i,
  output logic [11:0]   joy_o,
  output logic          six_o
);

  logic [5:0]  meta_q, sync_q;
  logic [11:0] shadow_q, shadow_d, joy_q;
  logic        md_q, md_d, six_q, six_d, six_out_q;
  logic        up, down, left, right, p6, p9;
  logic        at_dir, at_md, at_det, at_commit;

  assign up    = sync_q[PIN_UP];
  assign down  = sync_q[PIN_DOWN];
  assign left  = sync_q[PIN_LEFT];
  assign right = sync_q[PIN_RIGHT];
  assign p6    = sync_q[PIN_P6];
  assign p9    = sync_q[PIN_P9];

  assign at_dir    = tick_i && (ph_nxt_i == PW'(PH_READ_DIR));
  assign at_md     = tick_i && (ph_nxt_i == PW'(PH_READ_MD));
  assign at_det    = tick_i && (ph_nxt_i == PW'(PH_DETECT6));
  assign at_commit = tick_i && (ph_nxt_i == PW'(PH_COMMIT));

  always_comb begin
    shadow_d = shadow_q;
    md_d     = md_q;
    six_d    = six_q;
    if (at_dir) begin
      shadow_d       = '1;
      shadow_d[JB_U] = up;
      shadow_d[JB_D] = down;
      shadow_d[JB_L] = left;
      shadow_d[JB_R] = right;
      shadow_d[JB_B] = p6;
      shadow_d[JB_C] = p9;
      md_d           = 1'b0;
      six_d          = 1'b0;
    end
    if (at_md) begin
      // Left and right both low with select low identifies a Mega Drive pad.
      if (!right && !left) begin
        md_d           = 1'b1;
        shadow_d[JB_A] = p6;
        shadow_d[JB_S] = p9;
      end else begin
        shadow_d[JB_S] = 1'b1;
        shadow_d[JB_A] = 1'b1;
        shadow_d[JB_C] = p9;
        shadow_d[JB_B] = p6;
      end
    end
    if (at_det && six_en_i && md_q && !(up || down || left || right)) begin
      six_d = 1'b1;
    end
    if (at_commit && six_q) begin
      shadow_d[JB_M] = right;
      shadow_d[JB_X] = left;
      shadow_d[JB_Y] = down;
      shadow_d[JB_Z] = up;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      meta_q    <= '1;
      sync_q    <= '1;
      shadow_q  <= '1;
      md_q      <= 1'b0;
      six_q     <= 1'b0;
      joy_q     <= '1;
      six_out_q <= 1'b0;
    end else begin
      meta_q   <= pad_i;
      sync_q   <= meta_q;
      shadow_q <= shadow_d;
      md_q     <= md_d;
      six_q    <= six_d;
      if (at_commit) begin
        joy_q     <= shadow_d;
        six_out_q <= six_q;
      end
    end
  end

  assign joy_o = joy_q;
  assign six_o = six_out_q;

endmodule

// File: rtl/joy_sega_multi.sv
// Multi-port Sega pad poller: shared phase counter and select line driving
// NPORTS independent port decoders.
module joy_sega_multi
  import joy_sega_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int CYCLE_TICKS = 64
) (
  input  logic                   clk_i,
  input  logic                   res_n_i,
  input  logic                   tick_i,
  input  logic                   six_en_i,
  input  logic [NPORTS*6-1:0]    pad_i,
  output logic                   sel_o,
  output logic [NPORTS*12-1:0]   joy_o,
  output logic [NPORTS-1:0]      six_o,
  output logic                   valid_o
);

  localparam int PW = $clog2(CYCLE_TICKS);

  if (NPORTS < 1 || NPORTS > MAX_PORTS || CYCLE_TICKS < 16) begin : g_bad_params
    $error("joy_sega_multi: NPORTS must be 1..4 and CYCLE_TICKS at least 16");
  end

  logic [PW-1:0] ph_q, ph_d;
  logic          sel_q, valid_q;

  always_comb begin
    ph_d = ph_q;
    if (tick_i) begin
      ph_d = (ph_q == PW'(CYCLE_TICKS - 1)) ? '0 : ph_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      ph_q    <= '0;
      sel_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      valid_q <= tick_i && (ph_d == PW'(PH_COMMIT));
      if (tick_i) begin
        sel_q <= sel_level(int'(ph_d), six_en_i);
      end
    end
  end

  assign sel_o   = sel_q;
  assign valid_o = valid_q;

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    joy_sega_port #(
      .PW (PW)
    ) u_port (
      .clk_i    (clk_i),
      .res_n_i  (res_n_i),
      .tick_i   (tick_i),
      .six_en_i (six_en_i),
      .ph_nxt_i (ph_d),
      .pad_i    (pad_i[6*gi +: 6]),
      .joy_o    (joy_o[12*gi +: 12]),
      .six_o    (six_o[gi])
    );
  end

endmodule

// File: tb/tb_joy_sega_multi.sv
// Bench for joy_sega_multi: behavioural pad models react to sel_o, expected
// commits go through a scoreboard queue checked on every valid_o pulse.
module tb_joy_sega_multi;

  localparam int M_ABSENT = 0;
  localparam int M_SMS    = 1;
  localparam int M_MD3    = 2;
  localparam int M_MD6    = 3;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        tick = 1'b0;
  logic        six_en = 1'b1;
  logic [11:0] pad;
  logic        sel;
  logic [23:0] joy;
  logic [1:0]  six;
  logic        valid;

  logic [5:0]  pad16;
  logic        sel16;
  logic [11:0] joy16;
  logic [0:0]  six16;
  logic        valid16;

  int          mode0 = M_ABSENT;
  int          mode1 = M_ABSENT;
  logic [11:0] btn0 = 12'hFFF;
  logic [11:0] btn1 = 12'hFFF;
  int          tb_ph = 0;
  int          ph16 = 0;
  int          lows = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct packed {
    logic [23:0] joy;
    logic [1:0]  six;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  joy_sega_multi #(.NPORTS(2), .CYCLE_TICKS(64)) dut (
    .clk_i(clk), .res_n_i(res_n), .tick_i(tick), .six_en_i(six_en),
    .pad_i(pad), .sel_o(sel), .joy_o(joy), .six_o(six), .valid_o(valid)
  );

  joy_sega_multi #(.NPORTS(1), .CYCLE_TICKS(16)) dut16 (
    .clk_i(clk), .res_n_i(res_n), .tick_i(tick), .six_en_i(six_en),
    .pad_i(pad16), .sel_o(sel16), .joy_o(joy16), .six_o(six16), .valid_o(valid16)
  );

  // Pad pins from held buttons (btn in joy_o format, active-low). A six-button
  // pad answers all-directions-low in the first high phase after its third
  // select-low pulse, then M/X/Y/Z on the direction pins.
  function automatic logic [5:0] pad_pins(int mode, logic [11:0] b, logic s, int ph, int n_low);
    logic ext;
    ext = (mode == M_MD6) && (n_low >= 3);
    case (mode)
      M_SMS: return {b[5], b[4], b[3:0]};
      M_MD3, M_MD6: begin
        if (!s) return ext ? {b[7], b[6], 4'b0000} : {b[7], b[6], 2'b00, b[1:0]};
        if (ext) return (ph == 5) ? {b[5], b[4], 4'b0000} : {b[5], b[4], b[11:8]};
        return {b[5], b[4], b[3:0]};
      end
      default: return 6'h3F;
    endcase
  endfunction

  assign pad   = {pad_pins(mode1, btn1, sel, tb_ph, lows), pad_pins(mode0, btn0, sel, tb_ph, lows)};
  assign pad16 = 6'h3F;

  function automatic logic exp_sel(int ph, logic en);
    if (ph >= 5 || (ph % 2) == 1) return 1'b1;
    if (ph == 4) return !en;
    return 1'b0;
  endfunction

  function automatic logic [11:0] exp_joy(int mode, logic [11:0] b, bit six_ok);
    case (mode)
      M_ABSENT: return 12'hFFF;
      M_SMS:    return b | 12'hFC0;
      default:  return six_ok ? b : (b | 12'hF00);
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (phase %0d)", tag, got, want, tb_ph);
    end
  endtask

  task automatic push_exp(input bit s0, input bit s1);
    exp_t e;
    e.joy = {exp_joy(mode1, btn1, s1), exp_joy(mode0, btn0, s0)};
    e.six = {s1, s0};
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("[TB] commit joy=%06h six=%02b (expected %06h/%02b)", joy, six, e.joy, e.six);
        check_val("commit_joy", joy, e.joy);
        check_val("commit_six", six, e.six);
      end
    end
  end

  task automatic do_tick();
    logic sel_prev;
    @(negedge clk);
    sel_prev = sel;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    tb_ph = (tb_ph + 1) % 64;
    ph16 = (ph16 + 1) % 16;
    if (tb_ph == 0) lows = 0;
    if (sel_prev && !sel) lows++;
    check_val("sel", sel, exp_sel(tb_ph, six_en));
    check_val("sel16", sel16, exp_sel(ph16, six_en));
    check_val("valid", valid, tb_ph == 7);
    check_val("valid16", valid16, ph16 == 7);
    @(negedge clk);
    check_val("valid_width", {valid, valid16}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_to_commit();
    int n;
    n = 0;
    do begin
      do_tick();
      n++;
    end while (tb_ph != 7 && n < 70);
    check_val("commit_reached", tb_ph, 7);
  endtask

  task automatic do_reset(input bit with_tick);
    @(negedge clk);
    res_n = 1'b0;
    tick = with_tick;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    tb_ph = 0;
    ph16 = 0;
    lows = 0;
    sb_q.delete();
    check_val("rst_sel", sel, 1'b1);
    check_val("rst_valid", valid, 1'b0);
    check_val("rst_joy", joy, 24'hFFFFFF);
    check_val("rst_six", six, 2'b00);
    check_val("rst_sel16", sel16, 1'b1);
    check_val("rst_joy16", joy16, 12'hFFF);
    check_val("rst_six16", six16, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    do_reset(1'b0);

    // Absent pads; first commit at tick 7, short-cycle instance over 40 ticks.
    push_exp(1'b0, 1'b0);
    run_to_commit();
    repeat (33) do_tick();

    // Port 0 six-button Up+A+Z, port 1 SMS Up+button1.
    mode0 = M_MD6; btn0 = ~12'h141;
    mode1 = M_SMS; btn1 = ~12'h011;
    push_exp(1'b1, 1'b0);
    run_to_commit();

    // Same pads with six-button probing disabled.
    six_en = 1'b0;
    push_exp(1'b0, 1'b0);
    run_to_commit();

    // Port 0 three-button R+C+S, port 1 six-button D+B+X+M.
    six_en = 1'b1;
    mode0 = M_MD3; btn0 = ~12'h0A8;
    mode1 = M_MD6; btn1 = ~12'hC12;
    push_exp(1'b0, 1'b1);
    run_to_commit();

    // Reset in phase 4 with Up held; a tick during reset must be ignored.
    mode0 = M_MD3; btn0 = ~12'h001;
    mode1 = M_ABSENT; btn1 = 12'hFFF;
    for (int i = 0; i < 70 && tb_ph != 4; i++) do_tick();
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      do_tick();
      check_val("joy_hold", joy, 24'hFFFFFF);
    end
    push_exp(1'b0, 1'b0);
    do_tick();
    check_val("joy_after_rst", joy, 24'hFFFFFE);

    check_val("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
